dm_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (5-bit address, 8-bit data, combinational read on `rd`, write on `posedge clk` when `wr`) between the CPU core (port 0) and a second requester such as a loader or debug port (port 1). Each port issues one read or write per request/acknowledge handshake. The arbiter serialises the requests with round-robin priority and drives the memory's `rd_mem`/`wr_mem`/address/data pins. It sits between `smpl_vhdl`, the second master and `DataMemory`.

---
 rtl/dm_arbiter.sv | 111 +++++++++++
 tb/tb_dm_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data memory between two request/ack ports.
// Each access takes 3 cycles: accept in IDLE, one ACC cycle on the memory pins, one ACK cycle.
module dm_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          rd_mem,
  output logic          wr_mem,
  output logic [AW-1:0] dm_abus,
  output logic [DW-1:0] dm_out_dbus,
  input  logic [DW-1:0] dm_in_dbus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic          owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          win;
  logic          accept;

  // On a tie the port that did not win last time is served.
  assign win    = p0_req ? (p1_req ? ~last : 1'b0) : 1'b1;
  assign accept = (state == IDLE) && (p0_req || p1_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (p0_req || p1_req) state_nxt = ACC;
      end
      ACC: begin
        wr_mem    = we_q;
        rd_mem    = ~we_q;
        state_nxt = ACK;
      end
      ACK: begin
        p0_ack    = ~owner;
        p1_ack    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      last    <= win;
      owner   <= win;
      we_q    <= win ? p1_we    : p0_we;
      addr_q  <= win ? p1_addr  : p0_addr;
      wdata_q <= win ? p1_wdata : p0_wdata;
    end
  end

  // Read data is captured only for the owner, at the edge that ends ACC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == ACC && !we_q) begin
      if (owner) rdata1_q <= dm_in_dbus;
      else       rdata0_q <= dm_in_dbus;
    end
  end

  assign dm_abus     = addr_q;
  assign dm_out_dbus = wdata_q;
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: transaction-level model predicts grants and data,
// a negedge monitor compares every cycle and pops expected results on each ack.
module tb_dm_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req [0:1];
  logic       we  [0:1];
  logic [4:0] addr [0:1];
  logic [7:0] wdata [0:1];
  logic       p0_ack, p1_ack, rd_mem, wr_mem, busy;
  logic [7:0] p0_rdata, p1_rdata, dm_out_dbus, dm_in_dbus;
  logic [4:0] dm_abus;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .dm_abus(dm_abus),
    .dm_out_dbus(dm_out_dbus), .dm_in_dbus(dm_in_dbus), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_init_val(input int i);
    return (i == 0) ? 8'h00 : 8'(7 - i);
  endfunction

  // Memory environment: combinational read, write on rising edge.
  logic [7:0] mem [32];
  assign dm_in_dbus = mem[dm_abus];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mem_init_val(i);
    forever begin
      @(posedge clk);
      if (wr_mem) mem[dm_abus] = dm_out_dbus;
    end
  end

  // Reference model: a server free every third cycle, round-robin on ties.
  typedef struct { int port; logic [7:0] data; int cyc; } exp_t;
  typedef struct { int port; int cyc; } ack_t;
  exp_t exp_q[$];
  ack_t ack_log[$];

  int         cyc = 0;
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_last = 1;
  logic       m_we = 1'b0;
  logic [4:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] m_rdata [0:1] = '{8'h00, 8'h00};
  logic [7:0] ref_mem [32];

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = mem_init_val(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_phase = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_we = 1'b0;
        m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
        exp_q.delete();
      end else if (m_phase == 0) begin
        if (req[0] || req[1]) begin
          if (req[0] && req[1]) m_owner = 1 - m_last;
          else                  m_owner = req[0] ? 0 : 1;
          m_last  = m_owner;
          m_we    = we[m_owner];
          m_addr  = addr[m_owner];
          m_wdata = wdata[m_owner];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_rdata[m_owner] = ref_mem[m_addr];
        exp_q.push_back('{port: m_owner, data: m_rdata[m_owner], cyc: cyc});
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Monitor: per-cycle pin checks plus scoreboard pop on each ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_outputs", {p0_ack, p1_ack, rd_mem, wr_mem, busy}, 5'b0);
        chk("rst_buses", {dm_abus, dm_out_dbus, p0_rdata, p1_rdata}, 29'b0);
      end else begin
        chk("busy", busy, m_phase != 0);
        chk("wr_mem", wr_mem, m_phase == 1 && m_we);
        chk("rd_mem", rd_mem, m_phase == 1 && !m_we);
        chk("dm_abus", dm_abus, m_addr);
        chk("dm_out_dbus", dm_out_dbus, m_wdata);
        chk("p0_ack", p0_ack, m_phase == 2 && m_owner == 0);
        chk("p1_ack", p1_ack, m_phase == 2 && m_owner == 1);
        chk("p0_rdata", p0_rdata, m_rdata[0]);
        chk("p1_rdata", p1_rdata, m_rdata[1]);
        for (int p = 0; p < 2; p++) begin
          if ((p == 0) ? p0_ack : p1_ack) begin
            ack_log.push_back('{port: p, cyc: cyc});
            if (exp_q.size() == 0) begin
              chk("unexpected_ack", 32'(p), 32'hFFFF);
            end else begin
              e = exp_q.pop_front();
              chk("ack_port", 32'(p), 32'(e.port));
              chk("ack_rdata", (p == 0) ? p0_rdata : p1_rdata, e.data);
              chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
          end
        end
      end
    end
  end

  // Issue one access; caller is at posedge+1. Returns at posedge+1 after the ack cycle.
  task automatic do_req(input int p, input logic w, input logic [4:0] a, input logic [7:0] d);
    bit got = 0;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? p0_ack : p1_ack) got = 1;
    end
    if (!got) chk("ack_timeout", 32'(p), 32'hFFFF);
    @(posedge clk);
    #1 req[p] = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    // Reset held with request pulses present.
    #3 req[0] = 1'b1; we[0] = 1'b1;
    #8 req[0] = 1'b0; req[1] = 1'b1;
    #6 req[1] = 1'b0; we[0] = 1'b0;
    #5 rst = 1'b1;
    @(posedge clk); #1;
    do_req(0, 1'b0, 5'd1, 8'h00);
    chk("t1_p0_rdata", p0_rdata, 8'h06);

    do_req(1, 1'b1, 5'd3, 8'hA5);
    do_req(0, 1'b0, 5'd3, 8'h00);
    chk("t2_p0_rdata", p0_rdata, 8'hA5);
    chk("t2_p1_rdata", p1_rdata, 8'h00);

    rst_pulse();
    ack_log.delete();
    fork
      do_req(0, 1'b0, 5'd2, 8'h00);
      do_req(1, 1'b0, 5'd1, 8'h00);
    join
    chk("tie_p0_rdata", p0_rdata, 8'h05);
    chk("tie_p1_rdata", p1_rdata, 8'h06);
    chk("tie_first", (ack_log.size() > 0) ? 32'(ack_log[0].port) : 32'hFF, 32'd0);

    // Reset during the ACC cycle of a write.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd0; wdata[0] = 8'hFF;
    @(posedge clk); #2;
    chk("racc_wr_before", wr_mem, 1'b1);
    rst = 1'b0;
    #1;
    chk("racc_wr_drop", wr_mem, 1'b0);
    req[0] = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("racc_mem0", mem[0], 8'h00);
    chk("racc_idle", busy, 1'b0);

    // p1 request rises during p0's ACC.
    ack_log.delete();
    fork
      do_req(0, 1'b0, 5'd2, 8'h00);
      begin @(posedge clk); #2; do_req(1, 1'b0, 5'd4, 8'h00); end
    join
    chk("late_acks", ack_log.size(), 2);
    if (ack_log.size() == 2)
      chk("late_gap", 32'(ack_log[1].cyc - ack_log[0].cyc), 32'd3);
    chk("late_p0_rdata", p0_rdata, 8'h05);
    chk("late_p1_rdata", p1_rdata, 8'h03);

    // Sustained contention.
    @(posedge clk); #1;
    ack_log.delete();
    fork
      for (int k = 0; k < 5; k++)
        do_req(0, 1'($urandom_range(0, 1)), 5'($urandom_range(8, 31)), 8'($urandom));
      for (int k = 0; k < 5; k++)
        do_req(1, 1'($urandom_range(0, 1)), 5'($urandom_range(8, 31)), 8'($urandom));
    join
    chk("cont_acks", ack_log.size(), 10);
    for (int i = 1; i < ack_log.size(); i++) begin
      chk("cont_alternate", 32'(ack_log[i].port), 32'(1 - ack_log[i-1].port));
      chk("cont_spacing", 32'(ack_log[i].cyc - ack_log[i-1].cyc), 32'd3);
    end

    // Random traffic with gaps.
    fork
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 do_req(0, 1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
      end
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 do_req(1, 1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
      end
    join
    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
